// File: rtl/score_round_ctrl.sv
// rtl/score_round_ctrl.sv - game-round sequencer for the score/high-score datapath
// Accumulates points during play, commits a new high score on game over and holds the result for display.
module score_round_ctrl #(
    parameter int SCORE_W     = 8,
    parameter int POINT_W     = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               point_valid,
    input  logic [POINT_W-1:0] point_val,
    input  logic               game_over,
    input  logic               clear_high,
    output logic [SCORE_W-1:0] current_score,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_record,
    output logic               busy,
    output logic               done,
    output logic [2:0]         state_o
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SUM_W = ((SCORE_W > POINT_W) ? SCORE_W : POINT_W) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_COMPARE = 3'd2,
        S_UPDATE  = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   hold_cnt;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;

    // Sum is formed one bit wider than either operand so it can never wrap.
    assign score_sum = SUM_W'(current_score) + SUM_W'(point_val);
    assign score_sat = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_PLAY;
            S_PLAY:    if (game_over) state_next = S_COMPARE;
            S_COMPARE: state_next = (current_score > high_score) ? S_UPDATE : S_SHOW;
            S_UPDATE:  state_next = S_SHOW;
            S_SHOW:    if (hold_cnt == '0) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            current_score <= '0;
            high_score    <= '0;
            new_record    <= 1'b0;
            hold_cnt      <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        current_score <= '0;
                        new_record    <= 1'b0;
                    end
                    if (clear_high) high_score <= '0;
                end
                S_PLAY: begin
                    if (point_valid) current_score <= score_sat;
                end
                S_UPDATE: begin
                    high_score <= current_score;
                    new_record <= 1'b1;
                end
                S_SHOW: begin
                    if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
                end
                default: ;
            endcase
            // Entering SHOW (from COMPARE or UPDATE) arms the display hold.
            if (state_next == S_SHOW && state != S_SHOW) hold_cnt <= HOLD_LAST;
        end
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_SHOW) && (hold_cnt == '0);
    assign state_o = state;

endmodule

// File: tb/tb_score_round_ctrl.sv
// tb/tb_score_round_ctrl.sv - scoreboard bench for score_round_ctrl
module tb_score_round_ctrl;

    localparam int SCORE_W = 8;
    localparam int POINT_W = 8;
    localparam int HOLD    = 16;

    typedef struct {
        int score;
        int high;
        int rec;
    } exp_t;

    logic               clk = 0;
    logic               rst_n = 0;
    logic               start = 0;
    logic               point_valid = 0;
    logic [POINT_W-1:0] point_val = '0;
    logic               game_over = 0;
    logic               clear_high = 0;
    logic [SCORE_W-1:0] current_score;
    logic [SCORE_W-1:0] high_score;
    logic               new_record;
    logic               busy;
    logic               done;
    logic [2:0]         state_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    int   show_cnt = 0;
    int   saw_update = 0;

    score_round_ctrl #(.SCORE_W(SCORE_W), .POINT_W(POINT_W), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .point_valid(point_valid),
        .point_val(point_val), .game_over(game_over), .clear_high(clear_high),
        .current_score(current_score), .high_score(high_score), .new_record(new_record),
        .busy(busy), .done(done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result per done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (state_o == 3'd1) saw_update = 0;
            if (state_o == 3'd3) saw_update = 1;
            if (state_o == 3'd4) show_cnt++;
            else show_cnt = 0;
            if (done) begin
                exp_t e;
                check("done_has_expect", (sb_q.size() > 0) ? 1 : 0, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("score_at_done", int'(current_score), e.score);
                    check("high_at_done", int'(high_score), e.high);
                    check("record_at_done", int'(new_record), e.rec);
                    check("update_path", saw_update, e.rec);
                end
                check("show_length", show_cnt, HOLD);
                check("done_state", int'(state_o), 4);
                check("busy_at_done", int'(busy), 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round();
        start = 1;
        tick();
        start = 0;
        check("round_started", int'(state_o), 1);
        check("score_cleared", int'(current_score), 0);
    endtask

    task automatic add_point(input int v);
        point_valid = 1;
        point_val   = POINT_W'(v);
        tick();
        point_valid = 0;
    endtask

    task automatic end_round(input int sc, input int hi, input int rec);
        exp_t e;
        e.score = sc;
        e.high  = hi;
        e.rec   = rec;
        sb_q.push_back(e);
        game_over = 1;
        tick();
        game_over   = 0;
        point_valid = 0;
    endtask

    task automatic wait_state(input int s, input string name);
        int found = 0;
        for (int k = 0; k < 200; k++) begin
            if (int'(state_o) == s) begin
                found = 1;
                break;
            end
            tick();
        end
        check(name, found, 1);
    endtask

    initial begin
        #12;
        check("rst_state", int'(state_o), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_high", int'(high_score), 0);
        rst_n = 1;
        tick();

        // Record round: 15 over 0
        start_round();
        add_point(5); add_point(5); add_point(5);
        check("accum_15", int'(current_score), 15);
        end_round(15, 15, 1);
        check("compare_state", int'(state_o), 2);
        wait_state(0, "round_a_idle");
        check("score_persists", int'(current_score), 15);
        check("record_persists", int'(new_record), 1);

        // Below and equal to high: no record
        start_round();
        add_point(10);
        end_round(10, 15, 0);
        wait_state(0, "round_b_idle");
        start_round();
        add_point(7); add_point(8);
        end_round(15, 15, 0);
        wait_state(0, "round_c_idle");

        // Async reset mid-PLAY
        start_round();
        add_point(4); add_point(5);
        check("score_9", int'(current_score), 9);
        #2 rst_n = 0;
        #1;
        check("arst_score", int'(current_score), 0);
        check("arst_high", int'(high_score), 0);
        check("arst_record", int'(new_record), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_state", int'(state_o), 0);
        #2 rst_n = 1;
        tick();

        // Record 12, then point and game_over in the same cycle -> 13
        start_round();
        add_point(12);
        end_round(12, 12, 1);
        wait_state(0, "round_d_idle");
        start_round();
        add_point(10);
        point_valid = 1;
        point_val   = 8'd3;
        end_round(13, 13, 1);
        wait_state(0, "round_e_idle");

        // clear_high ignored in PLAY and SHOW; start held in SHOW waits for IDLE
        start_round();
        clear_high = 1;
        tick();
        clear_high = 0;
        check("clear_in_play", int'(high_score), 13);
        add_point(7);
        end_round(7, 13, 0);
        wait_state(4, "enter_show");
        start = 1;
        clear_high = 1;
        wait_state(0, "show_exit_idle");
        clear_high = 0;
        check("clear_in_show", int'(high_score), 13);
        tick();
        start = 0;
        check("start_after_show", int'(state_o), 1);
        check("record_cleared", int'(new_record), 0);
        game_over = 1;
        sb_q.push_back('{score: 0, high: 13, rec: 0});
        tick();
        game_over = 0;
        wait_state(0, "round_f_idle");

        // clear_high in IDLE
        clear_high = 1;
        tick();
        clear_high = 0;
        check("clear_in_idle", int'(high_score), 0);
        check("clear_stays_idle", int'(state_o), 0);

        // Saturation
        start_round();
        add_point(200);
        check("sum_200", int'(current_score), 200);
        add_point(100);
        check("saturate_255", int'(current_score), 255);
        add_point(1);
        check("saturate_hold", int'(current_score), 255);
        end_round(255, 255, 1);
        wait_state(0, "round_g_idle");

        tick();
        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
